rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
//  Shares the single RTC register-bus driver (escribe/dir_out/dato_out, handshake fin) among three masters:
//  init sequencer, user-edit machine, periodic read machine. Grants one master at a time, holds the grant
//  until that master drops req, and routes the driver's fin back to the owner only.
//  A watchdog reclaims the bus from a hung master. Sits between the masters and the RTC bus driver.
// PARAMETERS
//  W        8     address/data width of the RTC bus
//  TIMEOUT  1024  max cycles a master may hold the grant in OWN (>=2)
//  GAP_CYC  2     idle bus cycles inserted after every release (>=1)
// PORTS
//  clk          in   1     system clock; single clock domain
//  reset        in   1     synchronous, active-high reset
//  req          in   3     request vector: [0]=init, [1]=user edit, [2]=periodic read
//  escribe_in   in   3     per-master write strobe
//  dir_in       in   3*W   packed {dir2,dir1,dir0} per-master register address
//  dato_in      in   3*W   packed {dato2,dato1,dato0} per-master write data
//  fin          in   1     driver transaction-done pulse
//  gnt          out  3     one-hot grant, registered
//  fin_out      out  3     fin & gnt[i]; per-master done
//  escribe      out  1     to driver: write strobe of the owner, else 0
//  dir_out      out  W     to driver: address of the owner, else 0
//  dato_out     out  W     to driver: data of the owner, else 0
//  busy         out  1     1 in SETTLE/OWN/GAP
//  timeout_err  out  1     one-cycle pulse when watchdog reclaims the bus
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, wd_cnt=0, gap_cnt=0, rr=0 (user preferred), timeout_err=0;
//   hence escribe=0, dir_out=0, dato_out=0, fin_out=0, busy=0. Reset mid-transfer drops gnt at that edge.
//  Arbitration (IDLE only): req[0] always wins; else if req[1]&req[2], rr picks (rr=0 -> user, 1 -> read);
//   else the single requester. No preemption once granted.
//  rr update: on granting master 1 set rr=1; on granting master 2 set rr=0; granting 0 leaves rr.
//  States:
//   IDLE   : gnt=0. any req -> SETTLE with gnt<=winner (gnt visible 1 cycle after req sampled).
//   SETTLE : 1 cycle; bus outputs forced 0 while owner stabilises. req[g]=0 -> GAP; else -> OWN, wd_cnt<=0.
//   OWN    : escribe/dir_out/dato_out = owner's inputs (combinational mux on registered gnt, 0 latency).
//            req[g]=0 -> GAP (gnt<=0). wd_cnt==TIMEOUT-1 -> GAP, timeout_err=1 for 1 cycle.
//            Both same cycle: GAP, timeout_err=0 (release wins). else wd_cnt++.
//   GAP    : gnt=0, bus outputs 0, gap_cnt counts GAP_CYC cycles, then IDLE; reqs ignored meanwhile.
//  fin_out[i]=fin&gnt[i]; fin while gnt=0 is dropped. fin and req drop in same cycle: fin_out still
//   delivered that cycle, then release.
//  gnt is one-hot or zero at all times; escribe never 1 outside OWN.
//  Widths: wd_cnt = clog2(TIMEOUT) bits, gap_cnt = clog2(GAP_CYC+1) bits; no wrap (saturates by exit).
// STRUCTURE
//  rtc_bus_defs.vh: NREQ=3, REQ_INIT=0, REQ_USER=1, REQ_READ=2, state encodings IDLE/SETTLE/OWN/GAP.
//  Sub-module rtc_arb_pick: combinational priority+round-robin picker (req, rr -> one-hot winner).
//  Top: state register, counters, output mux.
// TESTING
//  1 req=3'b010 only, owner drives dir=8'h21,dato=8'h45,escribe=1 -> gnt=010 one cycle later, SETTLE,
//    then dir_out=21,dato_out=45; fin pulse -> fin_out=010; req drop -> GAP 2 cycles, IDLE.
//  2 req=3'b110 held, masters release after 1 fin each -> grants alternate 010,100,010,...
//    with >=GAP_CYC idle cycles between.
//  3 req=3'b111 from IDLE -> gnt=001 first; while master 0 owns, no change to gnt despite req[1],req[2].
//  4 TIMEOUT=16, master 2 never drops req -> after 16 OWN cycles gnt=0, timeout_err pulses once, GAP.
//  5 reset asserted during OWN with escribe_in=1 -> next edge gnt=0, escribe=0, rr=0, state IDLE.
//  6 fin pulses while IDLE/GAP -> fin_out stays 000; req dropped during SETTLE -> GAP, escribe never 1.

Source files
------------

// File: rtl/rtc_bus_arbiter_pkg.sv
// Shared definitions for the RTC register-bus arbiter: master indices, FSM states, helpers.
package rtc_bus_arbiter_pkg;

    localparam int NREQ     = 3;
    localparam int REQ_INIT = 0;
    localparam int REQ_USER = 1;
    localparam int REQ_READ = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OWN    = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_e;

    // True while the current grant holder still asserts its request.
    function automatic logic owner_present(input logic [NREQ-1:0] req, input logic [NREQ-1:0] gnt);
        return |(req & gnt);
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_pick.sv
// Combinational winner picker: init master always wins, user/read share by round-robin.
module rtc_bus_arbiter_pick
    import rtc_bus_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            rr_i,
    output logic [NREQ-1:0] win_o
);

    always_comb begin
        win_o = '0;
        if (req_i[REQ_INIT]) begin
            win_o[REQ_INIT] = 1'b1;
        end else if (req_i[REQ_USER] && req_i[REQ_READ]) begin
            // rr_i = 0 favours the user-edit machine, 1 favours the periodic reader
            if (rr_i) begin
                win_o[REQ_READ] = 1'b1;
            end else begin
                win_o[REQ_USER] = 1'b1;
            end
        end else if (req_i[REQ_USER]) begin
            win_o[REQ_USER] = 1'b1;
        end else if (req_i[REQ_READ]) begin
            win_o[REQ_READ] = 1'b1;
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Arbiter sharing the RTC bus driver among init / user-edit / periodic-read masters.
// state  | meaning
// IDLE   | no owner, arbitrate any request
// SETTLE | grant issued, bus held at 0 for one cycle
// OWN    | owner drives bus, watchdog running
// GAP    | enforced idle cycles after release, requests ignored
module rtc_bus_arbiter
    import rtc_bus_arbiter_pkg::*;
#(
    parameter int W       = 8,
    parameter int TIMEOUT = 1024,
    parameter int GAP_CYC = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ-1:0]     escribe_i,
    input  logic [NREQ*W-1:0]   dir_i,
    input  logic [NREQ*W-1:0]   dato_i,
    input  logic                fin_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     fin_out_o,
    output logic                escribe_o,
    output logic [W-1:0]        dir_out_o,
    output logic [W-1:0]        dato_out_o,
    output logic                busy_o,
    output logic                timeout_err_o
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    arb_state_e         state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               rr_q, rr_d;
    logic               terr_q, terr_d;
    logic [NREQ-1:0]    win;
    logic               held;

    rtc_bus_arbiter_pick u_pick (
        .req_i (req_i),
        .rr_i  (rr_q),
        .win_o (win)
    );

    assign held = owner_present(req_i, gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        wd_cnt_d  = wd_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rr_d      = rr_q;
        terr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = ST_SETTLE;
                    gnt_d   = win;
                    if (win[REQ_USER]) begin
                        rr_d = 1'b1;
                    end else if (win[REQ_READ]) begin
                        rr_d = 1'b0;
                    end
                end
            end
            ST_SETTLE: begin
                if (!held) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else begin
                    state_d  = ST_OWN;
                    wd_cnt_d = '0;
                end
            end
            ST_OWN: begin
                // A voluntary release in the watchdog's last cycle is not an error.
                if (!held) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d   = ST_GAP;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                    terr_d    = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            wd_cnt_q  <= '0;
            gap_cnt_q <= '0;
            rr_q      <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            wd_cnt_q  <= wd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rr_q      <= rr_d;
            terr_q    <= terr_d;
        end
    end

    // Bus mux is gated by OWN so SETTLE and GAP present a quiet bus.
    always_comb begin
        escribe_o  = 1'b0;
        dir_out_o  = '0;
        dato_out_o = '0;
        if (state_q == ST_OWN) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q[i]) begin
                    escribe_o  = escribe_i[i];
                    dir_out_o  = dir_i[i*W +: W];
                    dato_out_o = dato_i[i*W +: W];
                end
            end
        end
    end

    assign gnt_o         = gnt_q;
    assign fin_out_o     = {NREQ{fin_i}} & gnt_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_err_o = terr_q;

    a_gnt_onehot0 : assert property (@(posedge clk_i) $onehot0(gnt_q));
    a_esc_own     : assert property (@(posedge clk_i) escribe_o |-> (state_q == ST_OWN));

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: a timeline reference model predicts every active bus cycle.
module tb_rtc_bus_arbiter;

    localparam int W       = 8;
    localparam int TIMEOUT = 16;
    localparam int GAP_CYC = 2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  gnt;
        logic [2:0]  fin_out;
        logic        esc;
        logic [7:0]  dir;
        logic [7:0]  dato;
        logic        busy;
        logic        terr;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  escribe = '0;
    logic [23:0] dir = '0;
    logic [23:0] dato = '0;
    logic        fin = 1'b0;
    logic [2:0]  gnt, fin_out;
    logic        esc_o, busy, terr;
    logic [7:0]  dir_o, dato_o;

    rtc_bus_arbiter #(.W(W), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_i         (req),
        .escribe_i     (escribe),
        .dir_i         (dir),
        .dato_i        (dato),
        .fin_i         (fin),
        .gnt_o         (gnt),
        .fin_out_o     (fin_out),
        .escribe_o     (esc_o),
        .dir_out_o     (dir_o),
        .dato_out_o    (dato_o),
        .busy_o        (busy),
        .timeout_err_o (terr)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   done = 1'b0;
    bit   end_checked = 1'b0;

    // Reference timeline: who owns the bus, whether it is still settling,
    // how many owned cycles have elapsed, and how many enforced idle cycles remain.
    int   m_owner = -1;
    bit   m_settling = 1'b0;
    int   m_owned = 0;
    int   m_gap_left = 0;
    bit   m_prefer_read = 1'b0;
    bit   m_terr = 1'b0;

    function automatic int arb_pick(input logic [2:0] r, input bit prefer_read);
        if (r[0]) return 0;
        if (r[1] && r[2]) return prefer_read ? 2 : 1;
        if (r[1]) return 1;
        if (r[2]) return 2;
        return -1;
    endfunction

    function automatic obs_t model_outputs();
        obs_t o;
        o = '0;
        o.cyc = 32'(cyc);
        if (m_owner >= 0) o.gnt = 3'(1 << m_owner);
        o.fin_out = fin ? o.gnt : 3'b000;
        if (m_owner >= 0 && !m_settling) begin
            o.esc  = escribe[m_owner];
            o.dir  = dir[m_owner*8 +: 8];
            o.dato = dato[m_owner*8 +: 8];
        end
        o.busy = (m_owner >= 0) || (m_gap_left > 0);
        o.terr = m_terr;
        return o;
    endfunction

    function automatic bit obs_active(input obs_t o);
        return (o.gnt != 0) || (o.fin_out != 0) || o.esc || (o.dir != 0) || (o.dato != 0) || o.busy || o.terr;
    endfunction

    task automatic model_edge();
        int w;
        if (reset) begin
            m_owner = -1; m_settling = 1'b0; m_owned = 0;
            m_gap_left = 0; m_prefer_read = 1'b0; m_terr = 1'b0;
            return;
        end
        m_terr = 1'b0;
        if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_owner < 0) begin
            w = arb_pick(req, m_prefer_read);
            if (w >= 0) begin
                m_owner = w;
                m_settling = 1'b1;
                if (w == 1) m_prefer_read = 1'b1;
                if (w == 2) m_prefer_read = 1'b0;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
            m_gap_left = GAP_CYC;
        end else if (m_settling) begin
            m_settling = 1'b0;
            m_owned = 0;
        end else if (m_owned + 1 == TIMEOUT) begin
            m_owner = -1;
            m_gap_left = GAP_CYC;
            m_terr = 1'b1;
        end else begin
            m_owned++;
        end
    endtask

    task automatic step(input logic r, input logic [2:0] q, input logic [2:0] e,
                        input logic [23:0] d, input logic [23:0] da, input logic f);
        obs_t o;
        @(posedge clk);
        model_edge();
        if (reset) armed = 1'b1;
        #1;
        reset = r; req = q; escribe = e; dir = d; dato = da; fin = f;
        cyc++;
        if (armed) begin
            o = model_outputs();
            if (reset || obs_active(o)) exp_q.push_back(o);
        end
    endtask

    task automatic rstep(input logic [2:0] q, input logic f);
        step(1'b0, q, 3'($urandom), 24'($urandom), 24'($urandom), f);
    endtask

    always @(negedge clk) begin
        obs_t got, e;
        if (armed && !done) begin
            got = {32'(cyc), gnt, fin_out, esc_o, dir_o, dato_o, busy, terr};
            if (reset || obs_active(got)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output cyc=%0d got gnt=%b fin_out=%b esc=%b dir=%h dato=%h busy=%b terr=%b required no activity",
                             cyc, gnt, fin_out, esc_o, dir_o, dato_o, busy, terr);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL bus_cycle cyc=%0d got gnt=%b fin_out=%b esc=%b dir=%h dato=%h busy=%b terr=%b | required cyc=%0d gnt=%b fin_out=%b esc=%b dir=%h dato=%h busy=%b terr=%b",
                                 cyc, got.gnt, got.fin_out, got.esc, got.dir, got.dato, got.busy, got.terr,
                                 e.cyc, e.gnt, e.fin_out, e.esc, e.dir, e.dato, e.busy, e.terr);
                    end
                end
            end
        end else if (done && !end_checked) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_expected got %0d pending required 0 (next cyc=%0d)", exp_q.size(), exp_q[0].cyc);
            end
            end_checked = 1'b1;
        end
    end

    initial begin
        logic [2:0] rq;
        logic [2:0] drop;
        logic       f;
        // reset for a few cycles, then idle
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 3'b000, 24'h0, 24'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 3'b000, 3'b000, 24'h0, 24'h0, 1'b0);

        // single user-edit master with fixed address/data, one fin then release
        for (int i = 0; i < 6; i++)
            step(1'b0, 3'b010, 3'b010, 24'h002100, 24'h004500, (i == 4));
        for (int i = 0; i < 5; i++) step(1'b0, 3'b000, 3'b000, 24'h0, 24'h0, 1'b0);

        // user and read both pending; owner drops req for a cycle after its fin
        drop = '0;
        for (int i = 0; i < 80; i++) begin
            rq = 3'b110 & ~drop;
            f = (gnt != 0) && ($urandom_range(0, 2) == 0);
            drop = f ? gnt : 3'b000;
            rstep(rq, f);
        end
        for (int i = 0; i < 4; i++) rstep(3'b000, 1'b0);

        // all three request: init wins and keeps the bus until it lets go
        for (int i = 0; i < 12; i++) rstep(3'b111, ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 30; i++) rstep(3'b110, ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 4; i++) rstep(3'b000, 1'b0);

        // read master hangs: watchdog reclaims
        for (int i = 0; i < 40; i++) rstep(3'b100, 1'b0);
        for (int i = 0; i < 4; i++) rstep(3'b000, 1'b0);

        // release exactly in the watchdog's final cycle
        for (int i = 0; i < 17; i++) rstep(3'b100, 1'b0);
        for (int i = 0; i < 5; i++) rstep(3'b000, 1'b0);

        // reset while user master owns and is writing
        for (int i = 0; i < 5; i++) step(1'b0, 3'b010, 3'b010, 24'($urandom), 24'($urandom), 1'b0);
        step(1'b1, 3'b010, 3'b010, 24'($urandom), 24'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 3'b110, 3'b111, 24'($urandom), 24'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) rstep(3'b000, 1'b0);

        // fin with nobody granted, and a request withdrawn during settle
        for (int i = 0; i < 4; i++) rstep(3'b000, 1'b1);
        rstep(3'b001, 1'b0);
        rstep(3'b000, 1'b1);
        for (int i = 0; i < 5; i++) rstep(3'b000, 1'b1);

        // random traffic with persistent requests and occasional resets
        rq = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
            step(($urandom_range(0, 299) == 0), rq, 3'($urandom), 24'($urandom), 24'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 8; i++) rstep(3'b000, 1'b0);

        @(posedge clk);
        #1;
        done = 1'b1;
        for (int i = 0; i < 4 && !end_checked; i++) @(posedge clk);
        if (!end_checked) begin
            n_checks++;
            n_fail++;
            $display("FAIL end_check_timeout got not-run required run");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
